// File: rtl/baud_rate_counter.sv
// -----------------------------------------------------------------------------
// baud_rate_counter
//
// Fractional clock divider producing the oversampled baud clock for the UART
// receiver. A phase accumulator advances by STEP = 2 * BAUD_RATE *
// SAMPLING_RATE every enabled clk edge. Each time it passes CLK_FREQ, `out`
// toggles. The result is an `out` clock whose long-term average frequency is
// exactly BAUD_RATE * SAMPLING_RATE Hz. Each half-period is floor or ceil of
// CLK_FREQ/STEP clk cycles.
//
// Ports:
//   clk   in   system clock; all state changes on its rising edge
//   rst_n in   asynchronous active-low reset (clears acc, out, tick)
//   en    in   count enable; low holds the block in its post-reset state
//   out   out  divided clock at BAUD_RATE*SAMPLING_RATE Hz, straight from a flop
//   tick  out  one-clk pulse coincident with each 0->1 transition of out
// -----------------------------------------------------------------------------
module baud_rate_counter #(
    parameter int CLK_FREQ      = 50_000_000,
    parameter int BAUD_RATE     = 115200,
    parameter int SAMPLING_RATE = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic out,
    output logic tick
);

    localparam int TARGET = BAUD_RATE * SAMPLING_RATE;
    localparam int STEP   = 2 * TARGET;
    localparam int ACC_W  = $clog2(CLK_FREQ + STEP) + 1;

    localparam logic [ACC_W-1:0] STEP_W = ACC_W'(STEP);
    localparam logic [ACC_W-1:0] CLK_W  = ACC_W'(CLK_FREQ);

    // Parameter sanity: a zero rate makes no sense, and a STEP above CLK_FREQ
    // would require more than one toggle per clk edge.
    if (SAMPLING_RATE < 1) begin : g_bad_sampling_rate
        $error("baud_rate_counter: SAMPLING_RATE must be >= 1");
    end
    if (BAUD_RATE < 1) begin : g_bad_baud_rate
        $error("baud_rate_counter: BAUD_RATE must be >= 1");
    end
    if (STEP > CLK_FREQ) begin : g_bad_step
        $error("baud_rate_counter: 2*BAUD_RATE*SAMPLING_RATE must not exceed CLK_FREQ");
    end

    // Phase accumulator; it always stays below CLK_FREQ.
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;
    logic             wrap;

    // ACC_W has one spare bit over CLK_FREQ + STEP, so the sum never overflows.
    always_comb begin
        sum  = acc + STEP_W;
        wrap = (sum >= CLK_W);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc  <= '0;
            out  <= 1'b0;
            tick <= 1'b0;
        end else if (!en) begin
            // Dropping en returns to the exact post-reset phase. This lets the
            // receiver re-align sampling to a start-bit edge.
            acc  <= '0;
            out  <= 1'b0;
            tick <= 1'b0;
        end else if (wrap) begin
            acc  <= sum - CLK_W;
            out  <= ~out;
            // tick fires only when out is about to rise.
            tick <= ~out;
        end else begin
            acc  <= sum;
            tick <= 1'b0;
        end
    end

endmodule

// File: tb/tb_baud_rate_counter.sv
// -----------------------------------------------------------------------------
// tb_baud_rate_counter
//
// Runs four configurations side by side:
//   a: CLK_FREQ=16, STEP=8        (integer ratio, period 4)
//   b: CLK_FREQ=10, STEP=6        (fractional ratio)
//   c: CLK_FREQ=8,  STEP=8        (boundary, toggles every clk)
//   d: default parameters         (long-run tick count)
//
// The reference model counts enabled edges n since reset or since en was low.
// From n it derives toggles = floor(n*STEP/CLK_FREQ), which gives the expected
// out (toggles odd), tick (toggles just became odd) and acc
// (n*STEP mod CLK_FREQ).
// -----------------------------------------------------------------------------
module tb_baud_rate_counter;

    localparam int NI = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [NI-1:0] en;
    logic [NI-1:0] outs;
    logic [NI-1:0] ticks;

    baud_rate_counter #(.CLK_FREQ(16), .BAUD_RATE(1), .SAMPLING_RATE(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en[0]), .out(outs[0]), .tick(ticks[0]));
    baud_rate_counter #(.CLK_FREQ(10), .BAUD_RATE(1), .SAMPLING_RATE(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en[1]), .out(outs[1]), .tick(ticks[1]));
    baud_rate_counter #(.CLK_FREQ(8), .BAUD_RATE(1), .SAMPLING_RATE(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .en(en[2]), .out(outs[2]), .tick(ticks[2]));
    baud_rate_counter dut_d (
        .clk(clk), .rst_n(rst_n), .en(en[3]), .out(outs[3]), .tick(ticks[3]));

    // ---------------- model state ----------------
    longint cf[NI] = '{16, 10, 8, 50_000_000};
    longint st[NI] = '{8, 6, 8, 921_600};
    string  out_tag[NI]  = '{"out_a", "out_b", "out_c", "out_d"};
    string  tick_tag[NI] = '{"tick_a", "tick_b", "tick_c", "tick_d"};

    longint n[NI];
    int     tick_cnt[NI];
    logic   exp_out_a;

    logic [1:0] exp_q[$];   // {out, tick} per instance, per cycle

    int n_compared   = 0;
    int n_mismatched = 0;

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_acc(input int i);
        return 32'((n[i] * st[i]) % cf[i]);
    endfunction

    task automatic check_acc();
        check("acc_a", 32'(dut_a.acc), exp_acc(0));
        check("acc_b", 32'(dut_b.acc), exp_acc(1));
        check("acc_c", 32'(dut_c.acc), exp_acc(2));
    endtask

    // ---------------- driver / scoreboard step ----------------
    // Inputs are set by the caller away from the edge. One rising edge
    // passes, the model pushes its expectation, and the outputs are sampled
    // 1 time unit later.
    task automatic step();
        longint     t0, t1;
        logic [1:0] e;
        @(posedge clk);
        for (int i = 0; i < NI; i++) begin
            if (!rst_n || !en[i]) begin
                n[i] = 0;
                exp_q.push_back(2'b00);
            end else begin
                t0 = (n[i] * st[i]) / cf[i];
                n[i]++;
                t1 = (n[i] * st[i]) / cf[i];
                exp_q.push_back({(t1 % 2) == 1, (t1 != t0) && ((t1 % 2) == 1)});
            end
        end
        #1;
        for (int i = 0; i < NI; i++) begin
            e = exp_q.pop_front();
            if (i == 0) exp_out_a = e[1];
            check(out_tag[i],  32'(outs[i]),  32'(e[1]));
            check(tick_tag[i], 32'(ticks[i]), 32'(e[0]));
            if (ticks[i]) tick_cnt[i]++;
        end
        check_acc();
    endtask

    task automatic clear_tick_cnt();
        for (int i = 0; i < NI; i++) tick_cnt[i] = 0;
    endtask

    // Counts edges until out_a rises; bounded so a stuck DUT still reaches the summary.
    task automatic first_rise_a(input string tag);
        int k;
        k = 0;
        for (int j = 1; j <= 8; j++) begin
            step();
            if (outs[0] && k == 0) k = j;
            if (k != 0) break;
        end
        // ceil(16/8) = 2
        check(tag, 32'(k), 32'd2);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        en    = '1;
        for (int i = 0; i < NI; i++) n[i] = 0;
        clear_tick_cnt();
        exp_out_a = 1'b0;

        // Reset state
        #2;
        for (int i = 0; i < NI; i++) begin
            check(out_tag[i],  32'(outs[i]),  32'd0);
            check(tick_tag[i], 32'(ticks[i]), 32'd0);
        end
        check_acc();
        step();
        step();

        // Release reset; first 10 edges cover one full period of b.
        rst_n = 1'b1;
        clear_tick_cnt();
        for (int j = 0; j < 10; j++) step();
        check("ticks10_a", 32'(tick_cnt[0]), 32'd3);   // edges 2, 6, 10
        check("ticks10_b", 32'(tick_cnt[1]), 32'd3);
        check("ticks10_c", 32'(tick_cnt[2]), 32'd5);   // every second edge
        for (int j = 0; j < 30; j++) step();

        // Async reset in the high phase of a
        for (int j = 0; j < 4 && !exp_out_a; j++) step();
        check("a_high_before_rst", 32'(outs[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            n[i] = 0;
            check(out_tag[i],  32'(outs[i]),  32'd0);
            check(tick_tag[i], 32'(ticks[i]), 32'd0);
        end
        check_acc();
        step();
        rst_n = 1'b1;
        first_rise_a("first_rise_after_rst");
        for (int j = 0; j < 13; j++) step();

        // en low for 5 cycles mid-period on a, then re-enable
        en[0] = 1'b0;
        for (int j = 0; j < 5; j++) step();
        en[0] = 1'b1;
        first_rise_a("first_rise_after_en");
        for (int j = 0; j < 12; j++) step();

        // Long run on default parameters: restart d from a clean phase
        en[3] = 1'b0;
        step();
        en[3] = 1'b1;
        clear_tick_cnt();
        for (int j = 0; j < 50_000; j++) step();
        // floor(50000 * 460800 / 5e7) = 460, allow +-1
        check("tick_cnt_d_in_range",
              32'((tick_cnt[3] >= 459) && (tick_cnt[3] <= 461)), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
